// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard inputs and stall/flush control outputs of hazard_ctrl
interface hazard_ctrl_if;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_use_rs, ID_use_rt, EX_MemRead;
  logic        ID_md_start, ID_mfhilo, branch_taken, jump;
  logic        PCWrite, IFWrite, IFflush, IDEXflush, md_busy;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  modport master (
    output ID_rs, ID_rt, EX_rt, ID_use_rs, ID_use_rt, EX_MemRead,
           ID_md_start, ID_mfhilo, branch_taken, jump,
    input  PCWrite, IFWrite, IFflush, IDEXflush, md_busy, state, stall_cnt, flush_cnt
  );
  modport slave (
    input  ID_rs, ID_rt, EX_rt, ID_use_rs, ID_use_rt, EX_MemRead,
           ID_md_start, ID_mfhilo, branch_taken, jump,
    output PCWrite, IFWrite, IFflush, IDEXflush, md_busy, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and mult/div hazard stalls, branch/jump flushes, perf counters
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL_LU = 2'd1, STALL_MD = 2'd2} state_e;
  state_e      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        lu, mdh, redirect, stall, md_busy;
  assign md_busy  = md_cnt_q != 4'd0;
  assign lu       = hz.EX_MemRead & (hz.EX_rt != 5'd0) &
                    ((hz.ID_use_rs & (hz.ID_rs == hz.EX_rt)) | (hz.ID_use_rt & (hz.ID_rt == hz.EX_rt)));
  assign mdh      = md_busy & (hz.ID_mfhilo | hz.ID_md_start);
  assign redirect = hz.branch_taken | hz.jump;
  assign stall    = (lu | mdh) & ~redirect;
  always_comb begin
    hz.PCWrite   = rst ? 1'b0 : ~stall;
    hz.IFWrite   = rst ? 1'b0 : ~stall & ~redirect;
    hz.IFflush   = rst ? 1'b0 : redirect;
    hz.IDEXflush = rst ? 1'b0 : stall | redirect;
    hz.md_busy   = md_busy;
    hz.state     = state_q;
    hz.stall_cnt = stall_cnt_q;
    hz.flush_cnt = flush_cnt_q;
  end
  // a flushed mult/div never starts; a fresh start overrides the countdown
  always_comb begin
    state_d     = lu & ~redirect ? STALL_LU : mdh & ~redirect ? STALL_MD : RUN;
    md_cnt_d    = hz.ID_md_start & ~md_busy & ~redirect ? 4'(MD_LAT) :
                  md_busy ? md_cnt_q - 4'd1 : 4'd0;
    stall_cnt_d = stall & (stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = redirect & (flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;
  localparam int MD_LAT = 4;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   rem = 0, m_state = 0, m_sc = 0, m_fc = 0;
  hazard_ctrl_if hz ();
  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (.clk(clk), .rst(rst), .hz(hz));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input logic [4:0] rs, rt, ert, input logic urs, urt, mr, mds, mfh, br, jp);
    hz.ID_rs = rs; hz.ID_rt = rt; hz.EX_rt = ert;
    hz.ID_use_rs = urs; hz.ID_use_rt = urt; hz.EX_MemRead = mr;
    hz.ID_md_start = mds; hz.ID_mfhilo = mfh; hz.branch_taken = br; hz.jump = jp;
  endtask
  task automatic cycle();
    bit lu, mdh, redir, stl;
    #1;
    lu = hz.EX_MemRead && hz.EX_rt != 0 &&
         ((hz.ID_use_rs && hz.ID_rs == hz.EX_rt) || (hz.ID_use_rt && hz.ID_rt == hz.EX_rt));
    mdh   = rem > 0 && (hz.ID_mfhilo || hz.ID_md_start);
    redir = hz.branch_taken || hz.jump;
    stl   = (lu || mdh) && !redir;
    chk("PCWrite",   16'(hz.PCWrite),   16'(!rst && !stl));
    chk("IFWrite",   16'(hz.IFWrite),   16'(!rst && !stl && !redir));
    chk("IFflush",   16'(hz.IFflush),   16'(!rst && redir));
    chk("IDEXflush", 16'(hz.IDEXflush), 16'(!rst && (stl || redir)));
    chk("md_busy",   16'(hz.md_busy),   16'(rem > 0));
    chk("state",     16'(hz.state),     16'(m_state));
    chk("stall_cnt", hz.stall_cnt,      16'(m_sc));
    chk("flush_cnt", hz.flush_cnt,      16'(m_fc));
    @(posedge clk);
    if (rst) begin
      rem = 0; m_state = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_state = (lu && !redir) ? 1 : (mdh && !redir) ? 2 : 0;
      if (stl && m_sc < 65535) m_sc++;
      if (redir && m_fc < 65535) m_fc++;
      rem = (hz.ID_md_start && rem == 0 && !redir) ? MD_LAT : (rem > 0 ? rem - 1 : 0);
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    // load-use on rs, then the bubble in EX
    set_in(5, 0, 5, 1, 0, 1, 0, 0, 0, 0); cycle();
    chk("lu_state", 16'(hz.state), 16'd1);
    chk("lu_cnt", hz.stall_cnt, 16'd1);
    set_in(5, 0, 5, 1, 0, 0, 0, 0, 0, 0); cycle();
    // register 0 never hazards
    set_in(0, 0, 0, 1, 1, 1, 0, 0, 0, 0); cycle();
    chk("r0_cnt", hz.stall_cnt, 16'd1);
    // mult/div then mfhi held
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (4) cycle();
    chk("md_state", 16'(hz.state), 16'd2);
    chk("md_done_IFWrite", 16'(hz.IFWrite), 16'd1);
    cycle();
    // load-use with branch
    set_in(7, 7, 7, 1, 1, 1, 0, 0, 1, 0); cycle();
    chk("lu_br_state", 16'(hz.state), 16'd0);
    // flushed mult/div does not start
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 1); cycle();
    chk("flushed_md", 16'(hz.md_busy), 16'd0);
    // reset mid mult/div
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    rst = 1'b1; cycle();
    chk("rst_busy", 16'(hz.md_busy), 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 50) == 0;
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) == 0, ($urandom % 3) == 0,
             ($urandom % 8) == 0, ($urandom % 8) == 0);
      cycle();
    end
    rst = 1'b0;
    set_in(3, 0, 3, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cycle();
    chk("stall_sat", hz.stall_cnt, 16'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 4: mult/div busy cycles after issue, legal range 1..15.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports ID_rs, ID_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 SHALL have ports ID_use_rs, ID_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have ports EX_MemRead  in  1, and EX_rt  in  5: load in EX and its destination register.
REQ-007 SHALL have ports ID_md_start  in  1  (mult/div in ID), and ID_mfhilo  in  1  (mfhi/mflo in ID).
REQ-008 SHALL have ports branch_taken, jump  in  1 each  redirect resolved this cycle.
REQ-009 SHALL have ports PCWrite, IFWrite, IFflush, IDEXflush  out  1 each  PC enable, IF/ID write enable, IF/ID flush, ID/EX bubble insert.
REQ-010 SHALL have ports md_busy  out  1; state  out  2 (0 RUN, 1 STALL_LU, 2 STALL_MD); stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-011 SHALL compute lu = EX_MemRead & (EX_rt != 0) & ((ID_use_rs & ID_rs == EX_rt) | (ID_use_rt & ID_rt == EX_rt)); combinational.
REQ-012 SHALL hold a 4-bit md_cnt; md_busy = (md_cnt != 0); md_cnt SHALL decrement by 1 each cycle while nonzero.
REQ-013 SHALL compute mdh = md_busy & (ID_mfhilo | ID_md_start).
REQ-014 SHALL define redirect = branch_taken | jump; stall = (lu | mdh) & ~redirect.
REQ-015 On redirect: PCWrite=1, IFWrite=0, IFflush=1, IDEXflush=1; the flushed ID instruction SHALL NOT start a mult/div.
REQ-016 On stall (no redirect): PCWrite=0, IFWrite=0, IFflush=0, IDEXflush=1.
REQ-017 Otherwise: PCWrite=1, IFWrite=1, IFflush=0, IDEXflush=0.
REQ-018 All four control outputs SHALL be combinational from inputs and md_cnt, with no added latency.
REQ-019 If ID_md_start & ~md_busy & ~redirect, md_cnt SHALL load MD_LAT on the next edge; a same-cycle load overrides the decrement.
REQ-020 A load-use stall SHALL last exactly one cycle for a given load, since EX_MemRead drops once the bubble enters EX.
REQ-021 The state register SHALL be next-state = STALL_LU if lu & ~redirect; else STALL_MD if mdh & ~redirect; else RUN. lu has priority over mdh.
REQ-022 stall_cnt SHALL increment on every cycle with stall=1; flush_cnt SHALL increment on every cycle with redirect=1. Both SHALL saturate at 16'hFFFF.
REQ-023 Simultaneous lu and mdh SHALL produce one stall cycle per cycle and increment stall_cnt by 1, not 2.
REQ-024 Register 0 SHALL never cause a load-use hazard.

Reset
REQ-025 While rst=1 at a rising edge: md_cnt=0, state=RUN, stall_cnt=0, flush_cnt=0.
REQ-026 While rst=1, the outputs SHALL be forced PCWrite=0, IFWrite=0, IFflush=0, IDEXflush=0.
REQ-027 rst asserted during a mult/div busy period SHALL clear md_busy on the next edge.
REQ-028 After rst deasserts, outputs SHALL follow REQ-015..REQ-017 in the same cycle.

Verification
REQ-029 EX_MemRead=1, EX_rt=5, ID_use_rs=1, ID_rs=5 for 1 cycle -> PCWrite=0, IFWrite=0, IDEXflush=1; next state=1; stall_cnt=1.
REQ-030 Same as REQ-029 with EX_rt=0 -> no stall; PCWrite=1, IFWrite=1; stall_cnt unchanged.
REQ-031 ID_md_start for 1 cycle (MD_LAT=4), then ID_mfhilo held -> md_busy high 4 cycles; 4 stall cycles; state=2; IFWrite=1 on 5th cycle.
REQ-032 lu=1 and branch_taken=1 together -> IFflush=1, PCWrite=1, IDEXflush=1; stall_cnt unchanged; flush_cnt+1; state=RUN.
REQ-033 rst=1 asserted 2 cycles into a mult/div busy period -> all outputs 0 during rst; md_busy=0, counters=0 after the edge.
REQ-034 Force continuous stall for 65540 cycles -> stall_cnt holds at 16'hFFFF.
